// File: rtl/serv_rf_ram_seq.sv
// Sequencer between the bit-serial register file ports and a simple dual-port RAM.
// Optional macro SERV_RF_SEQ_X0_MASK_EN: register 0 reads as zero and is never written.
module serv_rf_ram_seq #(
    parameter  int WIDTH    = 2,
    parameter  int WITH_CSR = 1,
    localparam int RW       = 5 + WITH_CSR,
    localparam int L        = $clog2(WIDTH),
    localparam int AW       = RW + 5 - L
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rreq,
    input  logic [RW-1:0]    i_rreg0,
    input  logic [RW-1:0]    i_rreg1,
    output logic             o_ready,
    output logic             o_rdata0,
    output logic             o_rdata1,
    input  logic             i_wgo,
    input  logic             i_wen0,
    input  logic             i_wen1,
    input  logic [RW-1:0]    i_wreg0,
    input  logic [RW-1:0]    i_wreg1,
    input  logic             i_wdata0,
    input  logic             i_wdata1,
    output logic             o_rbusy,
    output logic             o_wbusy,
    output logic [AW-1:0]    o_ram_raddr,
    output logic             o_ram_ren,
    input  logic [WIDTH-1:0] i_ram_rdata,
    output logic [AW-1:0]    o_ram_waddr,
    output logic [WIDTH-1:0] o_ram_wdata,
    output logic             o_ram_wen
);

    localparam logic [4:0] LMASK = 5'(WIDTH - 1);

    function automatic logic [AW-1:0] ram_addr(input logic [RW-1:0] r, input logic [4:0] bit_idx);
        ram_addr = (AW'(r) << (5 - L)) | AW'(bit_idx >> L);
    endfunction

    typedef enum logic {RIDLE, RRUN} rstate_t;

    rstate_t          rstate, rstate_nxt;
    logic [5:0]       rcnt;
    logic [4:0]       rphase;
    logic [RW-1:0]    rreg0, rreg1;
    logic             ren0, ren1, rbusy;
    logic             rtrig0, rtrig1;
    logic [WIDTH-1:0] rhold0, rshift0, rshift1;
    logic             rbit0, rbit1;

    assign rphase = rcnt[4:0] & LMASK;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rstate <= RIDLE;
        else          rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            RIDLE:   if (i_rreq) rstate_nxt = RRUN;
            RRUN:    if (rcnt == 6'd33) rstate_nxt = RIDLE;
            default: rstate_nxt = RIDLE;
        endcase
    end

    // Port 0 word is fetched first, port 1 one cycle later; port 0 is re-aligned in rhold0.
    always_comb begin
        ren0  = 1'b0;
        ren1  = 1'b0;
        rbusy = 1'b0;
        if (rstate == RRUN) begin
            rbusy = 1'b1;
            ren0  = !rcnt[5] && (rphase == 5'd0);
            ren1  = !rcnt[5] && (rphase == 5'd1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rcnt    <= '0;
            rreg0   <= '0;
            rreg1   <= '0;
            rtrig0  <= 1'b0;
            rtrig1  <= 1'b0;
            rhold0  <= '0;
            rshift0 <= '0;
            rshift1 <= '0;
        end else begin
            if (rstate == RIDLE && i_rreq) begin
                rreg0 <= i_rreg0;
                rreg1 <= i_rreg1;
                rcnt  <= '0;
            end else if (rstate == RRUN) begin
                rcnt <= rcnt + 6'd1;
            end
            rtrig0 <= ren0;
            rtrig1 <= ren1;
            if (rtrig0) rhold0 <= i_ram_rdata;
            if (rtrig1) begin
                rshift0 <= rhold0 >> 1;
                rshift1 <= i_ram_rdata >> 1;
            end else begin
                rshift0 <= rshift0 >> 1;
                rshift1 <= rshift1 >> 1;
            end
        end
    end

    // Bit 0 of each fresh word bypasses the shift registers so it appears on arrival.
    assign rbit0 = rtrig1 ? rhold0[0]      : rshift0[0];
    assign rbit1 = rtrig1 ? i_ram_rdata[0] : rshift1[0];

`ifdef SERV_RF_SEQ_X0_MASK_EN
    logic rzero0, rzero1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rzero0 <= 1'b0;
            rzero1 <= 1'b0;
        end else if (rstate == RIDLE && i_rreq) begin
            rzero0 <= (i_rreg0 == '0);
            rzero1 <= (i_rreg1 == '0);
        end
    end

    assign o_rdata0 = rbit0 & ~rzero0;
    assign o_rdata1 = rbit1 & ~rzero1;
`else
    assign o_rdata0 = rbit0;
    assign o_rdata1 = rbit1;
`endif

    assign o_ready     = rtrig1 && (rcnt == 6'd2);
    assign o_rbusy     = rbusy;
    assign o_ram_ren   = ren0 | ren1;
    assign o_ram_raddr = ren1 ? ram_addr(rreg1, rcnt[4:0]) : ram_addr(rreg0, rcnt[4:0]);

    logic [4:0]       wcnt;
    logic [RW-1:0]    wreg0, wreg1, hreg0, hreg1;
    logic             wen0, wen1, hen0, hen1;
    logic [WIDTH-1:0] wsh0, wsh1, whold0, whold1;
    logic [WIDTH-1:0] wnext0, wnext1;
    logic [4:0]       hidx;
    logic             wdone, wpend0, wpend1;
    logic             wen0_in, wen1_in;

    assign wnext0 = (wsh0 >> 1) | (WIDTH'(i_wdata0) << (WIDTH - 1));
    assign wnext1 = (wsh1 >> 1) | (WIDTH'(i_wdata1) << (WIDTH - 1));
    assign wdone  = i_wgo && ((wcnt & LMASK) == LMASK);

`ifdef SERV_RF_SEQ_X0_MASK_EN
    assign wen0_in = i_wen0 && (i_wreg0 != '0);
    assign wen1_in = i_wen1 && (i_wreg1 != '0);
`else
    assign wen0_in = i_wen0;
    assign wen1_in = i_wen1;
`endif

    // Completed words and their targets are held so a following write burst cannot disturb them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wcnt   <= '0;
            wreg0  <= '0;
            wreg1  <= '0;
            wen0   <= 1'b0;
            wen1   <= 1'b0;
            wsh0   <= '0;
            wsh1   <= '0;
            whold0 <= '0;
            whold1 <= '0;
            hreg0  <= '0;
            hreg1  <= '0;
            hen0   <= 1'b0;
            hen1   <= 1'b0;
            hidx   <= '0;
            wpend0 <= 1'b0;
            wpend1 <= 1'b0;
        end else begin
            if (i_wgo) begin
                wcnt <= wcnt + 5'd1;
                wsh0 <= wnext0;
                wsh1 <= wnext1;
                if (wcnt == 5'd0) begin
                    wreg0 <= i_wreg0;
                    wreg1 <= i_wreg1;
                    wen0  <= wen0_in;
                    wen1  <= wen1_in;
                end
            end else begin
                wcnt <= '0;
            end
            wpend0 <= wdone;
            wpend1 <= wpend0;
            if (wdone) begin
                whold0 <= wnext0;
                whold1 <= wnext1;
                hidx   <= wcnt;
                hreg0  <= wreg0;
                hreg1  <= wreg1;
                hen0   <= wen0;
                hen1   <= wen1;
            end
        end
    end

    assign o_ram_wen   = (wpend0 & hen0) | (wpend1 & hen1);
    assign o_ram_waddr = wpend1 ? ram_addr(hreg1, hidx) : ram_addr(hreg0, hidx);
    assign o_ram_wdata = wpend1 ? whold1 : whold0;
    assign o_wbusy     = i_wgo | wpend0 | wpend1;

endmodule

// File: tb/tb_serv_rf_ram_seq.sv
// Bench for serv_rf_ram_seq with a behavioural dual-port RAM and queue-based scoreboards.
module tb_serv_rf_ram_seq;

    localparam int WIDTH    = 2;
    localparam int WITH_CSR = 1;
    localparam int RW       = 5 + WITH_CSR;
    localparam int AW       = RW + 5 - $clog2(WIDTH);
    localparam int NW       = 32 / WIDTH;
    localparam int EW       = AW + WIDTH;
    localparam int OW       = 7 + 2 * AW + WIDTH;
`ifdef SERV_RF_SEQ_X0_MASK_EN
    localparam bit X0_MASK = 1'b1;
`else
    localparam bit X0_MASK = 1'b0;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_rreq = 1'b0;
    logic [RW-1:0]    i_rreg0 = '0, i_rreg1 = '0;
    logic             o_ready, o_rdata0, o_rdata1;
    logic             i_wgo = 1'b0, i_wen0 = 1'b0, i_wen1 = 1'b0;
    logic [RW-1:0]    i_wreg0 = '0, i_wreg1 = '0;
    logic             i_wdata0 = 1'b0, i_wdata1 = 1'b0;
    logic             o_rbusy, o_wbusy;
    logic [AW-1:0]    o_ram_raddr, o_ram_waddr;
    logic             o_ram_ren, o_ram_wen;
    logic [WIDTH-1:0] i_ram_rdata = '0;
    logic [WIDTH-1:0] o_ram_wdata;

    logic             pre_en = 1'b0;
    logic [AW-1:0]    pre_addr = '0;
    logic [WIDTH-1:0] pre_data = '0;
    logic [WIDTH-1:0] mem [2**AW];

    logic [1:0]    rd_q[$];
    logic [EW-1:0] wr_q[$];
    int n_checks = 0;
    int n_err = 0;

    logic [OW-1:0] all_out;
    assign all_out = {o_ready, o_rdata0, o_rdata1, o_rbusy, o_wbusy, o_ram_ren, o_ram_wen,
                      o_ram_raddr, o_ram_waddr, o_ram_wdata};

    serv_rf_ram_seq #(.WIDTH(WIDTH), .WITH_CSR(WITH_CSR)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rreq(i_rreq), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_ready(o_ready), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .i_wgo(i_wgo),
        .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1), .o_rbusy(o_rbusy), .o_wbusy(o_wbusy),
        .o_ram_raddr(o_ram_raddr), .o_ram_ren(o_ram_ren), .i_ram_rdata(i_ram_rdata),
        .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata), .o_ram_wen(o_ram_wen)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        if (o_ram_ren) i_ram_rdata <= mem[o_ram_raddr];
        if (o_ram_wen) mem[o_ram_waddr] <= o_ram_wdata;
        if (pre_en)    mem[pre_addr] <= pre_data;
    end

    function automatic logic [EW-1:0] wexp(input logic [RW-1:0] r, input int w, input logic [31:0] d);
        return {AW'(int'(r) * NW + w), d[WIDTH*w +: WIDTH]};
    endfunction

    task automatic preload(input logic [RW-1:0] r, input logic [31:0] d);
        for (int w = 0; w < NW; w++) begin
            @(posedge i_clk); #1;
            pre_en   = 1'b1;
            pre_addr = AW'(int'(r) * NW + w);
            pre_data = d[WIDTH*w +: WIDTH];
        end
        @(posedge i_clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        n_checks++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL %s: outputs=%h expected 0", name, all_out);
        end
    endtask

    task automatic run_read(input logic [RW-1:0] r0, input logic [RW-1:0] r1, input logic [31:0] e0,
                            input logic [31:0] e1, input bit dup, input int abort_bit);
        int readies;
        logic [1:0] exp;
        rd_q.delete();
        for (int i = 0; i < 32; i++) rd_q.push_back({e1[i], e0[i]});
        @(posedge i_clk); #1;
        i_rreq = 1'b1; i_rreg0 = r0; i_rreg1 = r1;
        readies = 0;
        for (int k = 1; k <= 36; k++) begin
            @(posedge i_clk); #1;
            i_rreq = dup && (k == 10);
            if (dup && k == 10) begin i_rreg0 = 6'd1; i_rreg1 = 6'd2; end
            @(negedge i_clk);
            n_checks++;
            if (o_rbusy !== (k <= 34)) begin
                n_err++;
                $display("FAIL rbusy k=%0d: got %b expected %b", k, o_rbusy, (k <= 34));
            end
            if (o_ready === 1'b1) readies++;
            if (k == 3) begin
                n_checks++;
                if (o_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL ready at T+3: got %b expected 1", o_ready);
                end
            end
            if (k >= 3 && k <= 34) begin
                exp = rd_q.pop_front();
                n_checks++;
                if ({o_rdata1, o_rdata0} !== exp) begin
                    n_err++;
                    $display("FAIL rdata bit %0d: got %b%b expected %b", k - 3, o_rdata1, o_rdata0, exp);
                end
            end
            if (abort_bit >= 0 && k == abort_bit + 3) break;
        end
        if (abort_bit >= 0) begin
            i_rst_n = 1'b0;
            @(posedge i_clk); #1;
            check_all_zero("read abort");
            @(posedge i_clk); #1;
            i_rst_n = 1'b1;
            @(posedge i_clk); #1;
        end else begin
            n_checks++;
            if (readies != 1) begin
                n_err++;
                $display("FAIL ready pulses: got %0d expected 1", readies);
            end
        end
    endtask

    task automatic run_write(input logic [RW-1:0] r0, input logic [RW-1:0] r1, input logic e0,
                             input logic e1, input logic [31:0] d0, input logic [31:0] d1,
                             input int nbits, input int abort_bit);
        logic [EW-1:0] exp;
        int last_done, wens;
        wr_q.delete();
        for (int w = 0; w < nbits / WIDTH; w++) begin
            if (e0 && !(X0_MASK && r0 == '0)) wr_q.push_back(wexp(r0, w, d0));
            if (e1 && !(X0_MASK && r1 == '0)) wr_q.push_back(wexp(r1, w, d1));
        end
        last_done = (nbits / WIDTH) * WIDTH - 1;
        for (int c = 0; c < nbits + 4; c++) begin
            @(posedge i_clk); #1;
            i_wgo = (c < nbits);
            i_wreg0 = r0; i_wreg1 = r1; i_wen0 = e0; i_wen1 = e1;
            i_wdata0 = (c < nbits) ? d0[c % 32] : 1'b0;
            i_wdata1 = (c < nbits) ? d1[c % 32] : 1'b0;
            @(negedge i_clk);
            if (abort_bit >= 0) begin
                if (c == abort_bit) break;
            end else begin
                n_checks++;
                if (o_wbusy !== ((c < nbits) || (c <= last_done + 2))) begin
                    n_err++;
                    $display("FAIL wbusy c=%0d: got %b", c, o_wbusy);
                end
                if (o_ram_wen === 1'b1) begin
                    n_checks++;
                    if (wr_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected write c=%0d: addr=%h data=%h none expected", c, o_ram_waddr, o_ram_wdata);
                    end else begin
                        exp = wr_q.pop_front();
                        if ({o_ram_waddr, o_ram_wdata} !== exp) begin
                            n_err++;
                            $display("FAIL write c=%0d: got %h expected %h", c, {o_ram_waddr, o_ram_wdata}, exp);
                        end
                    end
                end
            end
        end
        if (abort_bit >= 0) begin
            i_wgo = 1'b0;
            i_rst_n = 1'b0;
            @(posedge i_clk); #1;
            check_all_zero("write abort");
            wens = 0;
            for (int c = 0; c < 20; c++) begin
                if (c == 2) i_rst_n = 1'b1;
                @(negedge i_clk);
                if (o_ram_wen === 1'b1) wens++;
                @(posedge i_clk); #1;
            end
            n_checks++;
            if (wens != 0) begin
                n_err++;
                $display("FAIL writes after reset: got %0d expected 0", wens);
            end
        end else begin
            n_checks++;
            if (wr_q.size() != 0) begin
                n_err++;
                $display("FAIL missing writes: got %0d left expected 0", wr_q.size());
            end
        end
        i_wgo = 1'b0; i_wen0 = 1'b0; i_wen1 = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_all_zero("reset state");
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check_all_zero("idle after reset");
    endtask

    task automatic test_read_stream();
        preload(6'd5, 32'hDEADBEEF);
        preload(6'd9, 32'h12345678);
        run_read(6'd5, 6'd9, 32'hDEADBEEF, 32'h12345678, 1'b0, -1);
    endtask

    task automatic test_write_port0();
        run_write(6'd3, 6'd11, 1'b1, 1'b0, 32'hA5A5A5A5, 32'hFFFFFFFF, 32, -1);
        run_read(6'd3, 6'd9, 32'hA5A5A5A5, 32'h12345678, 1'b0, -1);
    endtask

    task automatic test_csr_write();
        run_write(6'd2, 6'd34, 1'b0, 1'b1, 32'hFFFF0000, 32'h00000100, 32, -1);
        run_read(6'd3, 6'd34, 32'hA5A5A5A5, 32'h00000100, 1'b0, -1);
    endtask

    task automatic test_partial_write();
        preload(6'd12, 32'hF0F0F0F0);
        run_write(6'd12, 6'd13, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 9, -1);
        run_read(6'd12, 6'd5, 32'hF0F0F0FF, 32'hDEADBEEF, 1'b0, -1);
    endtask

    task automatic test_reset_abort();
        run_read(6'd5, 6'd9, 32'hDEADBEEF, 32'h12345678, 1'b0, 12);
        run_write(6'd7, 6'd8, 1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0, 32, 20);
        run_read(6'd5, 6'd9, 32'hDEADBEEF, 32'h12345678, 1'b0, -1);
    endtask

    task automatic test_dup_req();
        run_read(6'd9, 6'd5, 32'h12345678, 32'hDEADBEEF, 1'b1, -1);
    endtask

`ifdef SERV_RF_SEQ_X0_MASK_EN
    task automatic test_x0_mask();
        preload(6'd0, 32'h5A5A5A5A);
        run_write(6'd0, 6'd0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, -1);
        run_read(6'd0, 6'd0, 32'h0, 32'h0, 1'b0, -1);
    endtask
`endif

    initial begin
        test_reset();
        test_read_stream();
        test_write_port0();
        test_csr_write();
        test_partial_write();
        test_reset_abort();
        test_dup_req();
`ifdef SERV_RF_SEQ_X0_MASK_EN
        test_x0_mask();
`endif
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/serv_rf_ram_seq.md
Name: serv_rf_ram_seq

Overview:
Sequencer between the bit-serial register file interface and a simple dual-port synchronous RAM of width WIDTH. It schedules RAM reads so that two 32-bit registers stream out one bit per cycle on two read ports. It collects two serial write streams into WIDTH-bit words and commits them to the RAM. It sits below the RF interface decoding and above the RAM macro.

Parameters:
WIDTH, 2, RAM data width in bits; legal values are 2, 4, 8, 16 and 32. Each register occupies 32/WIDTH RAM words.
WITH_CSR, 1, adds a register-address MSB so that the four CSR slots at addresses 32-35 are reachable; RW = 5+WITH_CSR.
Derived: L = log2(WIDTH); AW = RW+5-L, the RAM address width. RAM address = {reg, bitidx[4:L]}.

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_rreq  in  1  single-cycle pulse that starts a read of both read ports
i_rreg0  in  RW  read port 0 register address; sampled on i_rreq
i_rreg1  in  RW  read port 1 register address; sampled on i_rreq
o_ready  out  1  high during the cycle in which read bit 0 is presented
o_rdata0  out  1  read port 0 serial data, LSB first
o_rdata1  out  1  read port 1 serial data, LSB first
i_wgo  in  1  write strobe; held high for exactly 32 consecutive cycles, one per bit
i_wen0  in  1  write port 0 enable; sampled on the first i_wgo cycle
i_wen1  in  1  write port 1 enable; sampled on the first i_wgo cycle
i_wreg0  in  RW  write port 0 register address; sampled on the first i_wgo cycle
i_wreg1  in  RW  write port 1 register address; sampled on the first i_wgo cycle
i_wdata0  in  1  write port 0 serial data, LSB first
i_wdata1  in  1  write port 1 serial data, LSB first
o_rbusy  out  1  read sequence in progress
o_wbusy  out  1  write commit in progress
o_ram_raddr  out  AW  RAM read address
o_ram_ren  out  1  RAM read enable
i_ram_rdata  in  WIDTH  RAM read data; valid one cycle after o_ram_ren
o_ram_waddr  out  AW  RAM write address
o_ram_wdata  out  WIDTH  RAM write data
o_ram_wen  out  1  RAM write enable

Behaviour:
- Reset: all counters, shift registers, latched addresses and enables clear to 0.
  - Outputs at reset: o_ready=0, o_rdata0/1=0, o_rbusy=0, o_wbusy=0, o_ram_ren=0, o_ram_wen=0, all addresses and data 0.
  - Reset asserted mid-sequence aborts the sequence immediately. No further RAM write is issued, even if a word is pending.
- Read FSM, states RIDLE then RRUN:
  - i_rreq in RIDLE (cycle T) latches both addresses, enters RRUN and clears the 6-bit counter rcnt.
  - rcnt increments every RRUN cycle. In RRUN, when rcnt[L-1:0]==0 and rcnt<32: issue ren for port 0, address {rreg0, rcnt[4:L]}.
  - When rcnt[L-1:0]==1: issue ren for port 1, address {rreg1, rcnt[4:L]}.
  - Returned words load the per-port WIDTH-bit shift registers. The port-0 word is delayed one cycle so both ports are aligned.
  - o_ready is high at cycle T+3. Bits 0..31 appear on o_rdata0/1 during cycles T+3..T+34, one per cycle.
  - Return to RIDLE after bit 31. o_rbusy is high from T+1 to T+34 inclusive.
  - i_rreq while o_rbusy is ignored.
- Write path:
  - Sampling: the first i_wgo cycle (W0) latches the addresses and enables. Each i_wgo cycle shifts i_wdata0/1 into per-port assemblers.
  - Completion: when the bit index mod WIDTH == WIDTH-1, both assembled words move to holding registers.
  - Commit: port 0 is written the next cycle if wen0 is set; port 1 is written the cycle after if wen1 is set.
    - Addresses are {wregN, wordidx}.
    - A disabled port leaves its slot idle with o_ram_wen=0.
  - Timing: the final commits occur at W0+32 and W0+33. o_wbusy is high from W0 to W0+33.
- Reads and writes use independent RAM ports and may overlap freely.
  - A same-address read and write in the same cycle returns the RAM's old data. The sequencer does no forwarding.
- i_wgo dropped before 32 bits: the partial word is discarded, the counter resets, and no commit occurs for that word.

Optional Feature:
Macro SERV_RF_SEQ_X0_MASK_EN.
- Defined: a read of register address 0 forces o_rdata0/1 to 0, and writes to register address 0 are suppressed (o_ram_wen stays 0).
- Undefined: register 0 is a plain RAM location; masking is done upstream.

Test Plan:
1. WIDTH=2, preload reg 5=0xDEADBEEF and reg 9=0x12345678; i_rreq at T with rreg0=5, rreg1=9 -> o_ready at T+3; o_rdata0 streams 0xDEADBEEF and o_rdata1 streams 0x12345678, LSB first, over T+3..T+34.
2. i_wgo for 32 cycles with wreg0=3, data 0xA5A5A5A5, wen0=1, wen1=0 -> 16 RAM writes at addresses {3,0..15}, and none for port 1; readback of reg 3 = 0xA5A5A5A5.
3. Write wreg1=34 (MEPC) with 0x00000100 and WITH_CSR=1 -> RAM address MSB set; readback on port 1 = 0x100.
4. Assert i_rst_n low at read bit 12 and at write bit 20 -> all outputs 0 next edge; no further o_ram_wen; a subsequent i_rreq completes normally.
5. Second i_rreq at T+10 during a read -> ignored; o_ready pulses exactly once.
6. With SERV_RF_SEQ_X0_MASK_EN: write 0xFFFFFFFF to reg 0 -> no o_ram_wen; read reg 0 -> all 32 bits 0.
